// File: rtl/eth_fcs_check_d16.sv
// eth_fcs_check_d16: receive-side Ethernet FCS checker on a 16-bit word stream.
// CRC32 is accumulated over every byte including the FCS. At end of frame the
// block issues one registered verdict (good / CRC error / runt / abort).
// Build macro FCS_CHECK_STATS_EN adds saturating good/bad verdict counters.
module eth_fcs_check_d16 #(
  parameter logic [31:0] RESIDUE   = 32'hC704DD7B,
  parameter int unsigned MIN_BYTES = 64,
  parameter int unsigned LEN_W     = 12
) (
  input  logic             sys_clk,
  input  logic             sys_rst,
  input  logic             in_valid,
  input  logic             in_sof,
  input  logic             in_eof,
  input  logic             in_odd,
  input  logic [15:0]      in_data,
  output logic             out_valid,
  output logic             out_ok,
  output logic             out_crc_err,
  output logic             out_runt,
  output logic             out_abort,
  output logic [LEN_W-1:0] out_len,
  output logic             busy
`ifdef FCS_CHECK_STATS_EN
  ,
  input  logic             stat_clr,
  output logic [31:0]      stat_good,
  output logic [31:0]      stat_bad
`endif
);

  localparam logic [31:0]      POLY    = 32'h04C11DB7;
  localparam logic [LEN_W-1:0] CNT_MAX = '1;
  localparam logic [LEN_W:0]   MIN_L   = (LEN_W+1)'(MIN_BYTES);

  typedef enum logic {S_IDLE, S_FRAME} state_t;

  typedef struct packed {
    logic             crc_err;
    logic             runt;
    logic             abort;
    logic [LEN_W-1:0] len;
  } verdict_t;

  // MSB-first register; each byte enters LSB first, i.e. bit-reversed.
  function automatic logic [31:0] crc_upd8(input logic [31:0] crc, input logic [7:0] b);
    logic [31:0] c;
    logic        fb;
    c = crc;
    for (int unsigned i = 0; i < 8; i++) begin
      fb = c[31] ^ b[i];
      c  = {c[30:0], 1'b0} ^ (fb ? POLY : '0);
    end
    return c;
  endfunction

  function automatic logic [31:0] crc_upd16(input logic [31:0] crc, input logic [15:0] w);
    return crc_upd8(crc_upd8(crc, w[7:0]), w[15:8]);
  endfunction

  function automatic logic [LEN_W-1:0] sat_add(input logic [LEN_W-1:0] a, input logic [1:0] n);
    logic [LEN_W:0] s;
    s = {1'b0, a} + {{(LEN_W-1){1'b0}}, n};
    return s[LEN_W] ? CNT_MAX : s[LEN_W-1:0];
  endfunction

  function automatic verdict_t mk_verdict(input logic [31:0] crc, input logic [LEN_W-1:0] cnt,
                                          input logic abort);
    verdict_t v;
    v.crc_err = (crc != RESIDUE);
    v.runt    = ({1'b0, cnt} < MIN_L);
    v.abort   = abort;
    v.len     = cnt;
    return v;
  endfunction

  state_t           r_state, w_state_n;
  logic [31:0]      r_crc, w_crc_n;
  logic [LEN_W-1:0] r_cnt, w_cnt_n;
  logic             r_pend_v, w_pend_v_n;
  verdict_t         r_pend, w_pend_n;

  logic             w_odd;
  logic [31:0]      w_crc_new, w_crc_acc;
  logic [LEN_W-1:0] w_cnt_new, w_cnt_acc;
  logic             w_v1_v, w_v2_v, w_emit_v;
  verdict_t         w_v1, w_v2, w_emit;

  // odd only counts on the last word of a frame
  assign w_odd     = in_eof & in_odd;
  assign w_crc_new = w_odd ? crc_upd8('1, in_data[7:0]) : crc_upd16('1, in_data);
  assign w_crc_acc = w_odd ? crc_upd8(r_crc, in_data[7:0]) : crc_upd16(r_crc, in_data);
  assign w_cnt_new = w_odd ? LEN_W'(1) : LEN_W'(2);
  assign w_cnt_acc = sat_add(r_cnt, w_odd ? 2'd1 : 2'd2);
  assign busy      = (r_state == S_FRAME);

  // state register
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) r_state <= S_IDLE;
    else         r_state <= w_state_n;
  end

  // next-state, CRC/count update and verdict selection
  always_comb begin
    w_state_n  = r_state;
    w_crc_n    = r_crc;
    w_cnt_n    = r_cnt;
    w_v1_v     = 1'b0;
    w_v1       = '0;
    w_v2_v     = 1'b0;
    w_v2       = '0;
    if (in_valid) begin
      unique case (r_state)
        S_IDLE: begin
          if (in_sof) begin
            w_crc_n = w_crc_new;
            w_cnt_n = w_cnt_new;
            if (in_eof) begin
              w_v1_v = 1'b1;
              w_v1   = mk_verdict(w_crc_new, w_cnt_new, 1'b0);
            end else begin
              w_state_n = S_FRAME;
            end
          end
        end
        S_FRAME: begin
          if (in_sof) begin
            // old frame reported as aborted; new frame loaded in the same cycle
            w_v1_v  = 1'b1;
            w_v1    = mk_verdict(r_crc, r_cnt, 1'b1);
            w_crc_n = w_crc_new;
            w_cnt_n = w_cnt_new;
            if (in_eof) begin
              w_v2_v    = 1'b1;
              w_v2      = mk_verdict(w_crc_new, w_cnt_new, 1'b0);
              w_state_n = S_IDLE;
            end
          end else begin
            w_crc_n = w_crc_acc;
            w_cnt_n = w_cnt_acc;
            if (in_eof) begin
              w_v1_v    = 1'b1;
              w_v1      = mk_verdict(w_crc_acc, w_cnt_acc, 1'b0);
              w_state_n = S_IDLE;
            end
          end
        end
        default: w_state_n = S_IDLE;
      endcase
    end
    // a held verdict always goes out before anything produced this cycle
    if (r_pend_v) begin
      w_emit_v   = 1'b1;
      w_emit     = r_pend;
      w_pend_v_n = w_v1_v;
      w_pend_n   = w_v1;
    end else begin
      w_emit_v   = w_v1_v;
      w_emit     = w_v1;
      w_pend_v_n = w_v2_v;
      w_pend_n   = w_v2;
    end
  end

  // datapath registers and registered verdict outputs
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      r_crc       <= '1;
      r_cnt       <= '0;
      r_pend_v    <= 1'b0;
      r_pend      <= '0;
      out_valid   <= 1'b0;
      out_ok      <= 1'b0;
      out_crc_err <= 1'b0;
      out_runt    <= 1'b0;
      out_abort   <= 1'b0;
      out_len     <= '0;
    end else begin
      r_crc       <= w_crc_n;
      r_cnt       <= w_cnt_n;
      r_pend_v    <= w_pend_v_n;
      r_pend      <= w_pend_n;
      out_valid   <= w_emit_v;
      out_ok      <= w_emit_v & ~w_emit.crc_err & ~w_emit.runt & ~w_emit.abort;
      out_crc_err <= w_emit_v & w_emit.crc_err;
      out_runt    <= w_emit_v & w_emit.runt;
      out_abort   <= w_emit_v & w_emit.abort;
      out_len     <= w_emit_v ? w_emit.len : '0;
    end
  end

`ifdef FCS_CHECK_STATS_EN
  logic [31:0] r_stat_good, r_stat_bad;

  // saturating verdict counters; clear wins over a coincident verdict
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      r_stat_good <= '0;
      r_stat_bad  <= '0;
    end else if (stat_clr) begin
      r_stat_good <= '0;
      r_stat_bad  <= '0;
    end else if (out_valid) begin
      if (out_ok) begin
        if (r_stat_good != '1) r_stat_good <= r_stat_good + 32'd1;
      end else begin
        if (r_stat_bad != '1) r_stat_bad <= r_stat_bad + 32'd1;
      end
    end
  end

  assign stat_good = r_stat_good;
  assign stat_bad  = r_stat_bad;
`else
  // statistics counters not built
`endif

endmodule
